usb_serial_rx_fifo: RTL and testbench
=====================================

Name: usb_serial_rx_fifo

Overview:
- Inbound byte buffer placed directly downstream of the USB serial device's receive side, i.e. the uart_rx_strobe / uart_rx_data pair.
- Replaces the single-byte receive holding register in the memory-mapped serial peripheral, so bytes arriving in bursts from the host are not lost while the CPU is busy.
- Presents the bus side with a first-word-fall-through head byte, occupancy count, high-water flag and overflow diagnostics.

Parameters:
ADDR_BITS  4  log2 of FIFO depth; depth = 2**ADDR_BITS = 16 bytes by default.
HIGH_WATER  12  occupancy at or above which high_water asserts; legal range 1..2**ADDR_BITS.

Ports:
clk  input  1  system clock; all logic on posedge.
reset  input  1  asynchronous, active-high reset.
rx_strobe  input  1  one-cycle pulse; rx_data is valid this cycle.
rx_data  input  8  received byte from the USB serial device.
pop_strobe  input  1  consumer removes the head byte at this edge.
read_data  output  8  head byte; forced to 0 while empty.
data_available  output  1  FIFO is non-empty.
space_available  output  1  FIFO is not full.
count  output  ADDR_BITS+1  current occupancy, 0..2**ADDR_BITS.
high_water  output  1  count >= HIGH_WATER.
overflow  output  1  sticky; a byte was dropped because the FIFO was full.
dropped_count  output  8  number of bytes dropped since the last clear; saturates at 255.
overflow_clear  input  1  clears overflow and dropped_count.

Behaviour:
- Storage: array of 2**ADDR_BITS bytes with asynchronous read. Write pointer and read pointer are each ADDR_BITS+1 wide; the extra MSB distinguishes full from empty.
- Pointers wrap modulo 2**(ADDR_BITS+1) with no special case.
- empty = (wr_ptr == rd_ptr). full = (addresses equal) && (MSBs differ).
- count = wr_ptr - rd_ptr, computed modulo 2**(ADDR_BITS+1).
- Reset: wr_ptr = rd_ptr = 0, overflow = 0, dropped_count = 0. As a result, count = 0, data_available = 0, space_available = 1, high_water = 0 and read_data = 0. Array contents are don't-care.
- Reset may assert at any time. It immediately discards all contents, with no partial-write side effects.
- Push: rx_strobe && !full at edge N writes mem[wr_ptr] and increments wr_ptr. data_available and read_data reflect the byte from cycle N+1, so push-to-visible latency is 1 cycle.
- Pop: pop_strobe && !empty at edge N increments rd_ptr. The next head, or read_data = 0 if the FIFO became empty, is visible from cycle N+1.
- pop_strobe while empty is ignored: no pointer change, no error flag.
- Push while full: the byte is dropped and wr_ptr is unchanged. overflow is set to 1. dropped_count increments, holding at 255.
- Simultaneous push and pop, not empty (including full): both are accepted and count is unchanged. Full status is evaluated before the pop, but a concurrent pop frees the slot, so the push is NOT dropped.
- Simultaneous push and pop, empty: push is accepted, pop is ignored. The new byte is not visible until the next cycle.
- overflow_clear at edge N sets overflow = 0 and dropped_count = 0, unless a drop occurs at the same edge. In that case set wins: overflow = 1, dropped_count = 1.
- high_water and space_available are combinational from the pointers. They update in the same cycle as count.
- No other state. The block never back-pressures rx_strobe; the upstream device has no ready input on its receive side.

Test Plan:
- Reset, then push 0x41,0x42,0x43 on consecutive cycles -> data_available rises the cycle after the first push; read_data = 0x41, count = 3. Three pops return 0x41,0x42,0x43 in order, then data_available = 0 and read_data = 0.
- Push 16 bytes 0x00..0x0F -> space_available = 0, count = 16, high_water asserts at count 12. Push 0xAA, 0xBB -> both dropped, overflow = 1, dropped_count = 2, head still 0x00.
- Full FIFO, push 0x55 with simultaneous pop -> count stays 16, head = 0x01, 0x55 emerges as the 16th byte, overflow unchanged.
- Empty FIFO, rx_strobe and pop_strobe in the same cycle with 0x7E -> the pop is ignored; next cycle count = 1, read_data = 0x7E.
- Push 300 bytes into a full FIFO -> dropped_count saturates at 255. overflow_clear together with a dropping push -> overflow = 1, dropped_count = 1. overflow_clear alone -> both 0.
- Wrap: run 40 push/pop cycles at 1-deep occupancy -> data order is preserved across pointer wrap and count never exceeds 1. Assert reset mid-stream -> count = 0 immediately, and a subsequent push of 0x33 reads back 0x33.

Source files
------------

// File: rtl/usb_serial_rx_fifo.sv
// usb_serial_rx_fifo: inbound byte FIFO behind the USB serial receive side.
// The head byte falls through to read_data. The block also reports occupancy,
// a high-water flag, and diagnostics for bytes dropped on overflow.
module usb_serial_rx_fifo #(
  parameter int unsigned ADDR_BITS  = 4,
  parameter int unsigned HIGH_WATER = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_strobe,
  input  logic [7:0]           rx_data,
  input  logic                 pop_strobe,
  output logic [7:0]           read_data,
  output logic                 data_available,
  output logic                 space_available,
  output logic [ADDR_BITS:0]   count,
  output logic                 high_water,
  output logic                 overflow,
  output logic [7:0]           dropped_count,
  input  logic                 overflow_clear
);

  localparam int unsigned DEPTH = 2 ** ADDR_BITS;
  localparam int unsigned PTR_W = ADDR_BITS + 1;

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             empty;
  logic             full;
  logic             pop_ok;
  logic             push_ok;
  logic             drop;

  // Status and handshake decode from the pointers.
  // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted.
  always_comb begin
    empty   = (wr_ptr == rd_ptr);
    full    = (wr_ptr[ADDR_BITS-1:0] == rd_ptr[ADDR_BITS-1:0]) &&
              (wr_ptr[ADDR_BITS] != rd_ptr[ADDR_BITS]);
    pop_ok  = pop_strobe && !empty;
    push_ok = rx_strobe && (!full || pop_ok);
    drop    = rx_strobe && !push_ok;
  end

  // Bus-side view: head byte (zero when empty), occupancy and flags.
  always_comb begin
    count           = PTR_W'(wr_ptr - rd_ptr);
    data_available  = !empty;
    space_available = !full;
    high_water      = (count >= PTR_W'(HIGH_WATER));
    read_data       = empty ? 8'h00 : mem[rd_ptr[ADDR_BITS-1:0]];
  end

  // Storage write; the array is not reset.
  always_ff @(posedge clk) begin
    if (push_ok && !reset) begin
      mem[wr_ptr[ADDR_BITS-1:0]] <= rx_data;
    end
  end

  // Pointer advance; both pointers wrap naturally across the extra MSB.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= PTR_W'(wr_ptr + 1'b1);
      if (pop_ok)  rd_ptr <= PTR_W'(rd_ptr + 1'b1);
    end
  end

  // Overflow diagnostics; a drop at the same edge as a clear wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow      <= 1'b0;
      dropped_count <= 8'h00;
    end else if (drop) begin
      overflow <= 1'b1;
      if (overflow_clear) begin
        dropped_count <= 8'h01;
      end else if (dropped_count != 8'hFF) begin
        dropped_count <= 8'(dropped_count + 8'h01);
      end
    end else if (overflow_clear) begin
      overflow      <= 1'b0;
      dropped_count <= 8'h00;
    end
  end

endmodule

// File: tb/tb_usb_serial_rx_fifo.sv
// tb_usb_serial_rx_fifo: directed plus randomized stimulus for usb_serial_rx_fifo.
// The bench keeps a queue-based reference model and compares every output to it each cycle.
module tb_usb_serial_rx_fifo;

  localparam int unsigned AB    = 4;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned HW    = 12;

  logic        clk;
  logic        reset;
  logic        rx_strobe;
  logic [7:0]  rx_data;
  logic        pop_strobe;
  logic [7:0]  read_data;
  logic        data_available;
  logic        space_available;
  logic [AB:0] count;
  logic        high_water;
  logic        overflow;
  logic [7:0]  dropped_count;
  logic        overflow_clear;

  usb_serial_rx_fifo #(.ADDR_BITS(AB), .HIGH_WATER(HW)) dut (
    .clk             (clk),
    .reset           (reset),
    .rx_strobe       (rx_strobe),
    .rx_data         (rx_data),
    .pop_strobe      (pop_strobe),
    .read_data       (read_data),
    .data_available  (data_available),
    .space_available (space_available),
    .count           (count),
    .high_water      (high_water),
    .overflow        (overflow),
    .dropped_count   (dropped_count),
    .overflow_clear  (overflow_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [7:0] q[$];
  bit         m_ovf;
  int         m_drop;

  int checks;
  int errors;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [7:0] head;
    int n;
    n    = q.size();
    head = (n > 0) ? q[0] : 8'h00;
    check_val("count",           32'(count),           32'(n));
    check_val("data_available",  32'(data_available),  32'(n > 0));
    check_val("space_available", 32'(space_available), 32'(n < DEPTH));
    check_val("high_water",      32'(high_water),      32'(n >= HW));
    check_val("read_data",       32'(read_data),       32'(head));
    check_val("overflow",        32'(overflow),        32'(m_ovf));
    check_val("dropped_count",   32'(dropped_count),   32'(m_drop));
  endtask

  // One clock of stimulus, model update at the edge, checks 1 time unit later.
  task automatic step(input bit rx, input logic [7:0] d, input bit pp, input bit clr);
    bit pop_acc;
    bit was_full;
    bit drop;
    rx_strobe      = rx;
    rx_data        = d;
    pop_strobe     = pp;
    overflow_clear = clr;
    @(posedge clk);
    pop_acc  = pp && (q.size() > 0);
    was_full = (q.size() == DEPTH);
    drop     = 1'b0;
    if (pop_acc) void'(q.pop_front());
    if (rx) begin
      if (!was_full || pop_acc) q.push_back(d);
      else drop = 1'b1;
    end
    if (drop) begin
      m_ovf  = 1'b1;
      m_drop = clr ? 1 : ((m_drop == 255) ? 255 : m_drop + 1);
    end else if (clr) begin
      m_ovf  = 1'b0;
      m_drop = 0;
    end
    #1;
    rx_strobe      = 1'b0;
    pop_strobe     = 1'b0;
    overflow_clear = 1'b0;
    check_outputs();
  endtask

  // Asynchronous reset applied between edges; the effect must be immediate.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    q.delete();
    m_ovf  = 1'b0;
    m_drop = 0;
    check_outputs();
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_outputs();
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rx_strobe      = 1'b0;
    rx_data        = 8'h00;
    pop_strobe     = 1'b0;
    overflow_clear = 1'b0;
    m_ovf          = 1'b0;
    m_drop         = 0;
    reset          = 1'b0;
    #2;
    do_reset();

    // Basic ordering
    step(1, 8'h41, 0, 0);
    step(1, 8'h42, 0, 0);
    step(1, 8'h43, 0, 0);
    check_val("head_41", 32'(read_data), 32'h41);
    check_val("count_3", 32'(count), 32'd3);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 1, 0);
    check_val("empty_read_zero", 32'(read_data), 32'h0);

    // Fill and overflow
    for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0);
    check_val("full_no_space", 32'(space_available), 32'd0);
    step(1, 8'hAA, 0, 0);
    step(1, 8'hBB, 0, 0);
    check_val("dropped_2", 32'(dropped_count), 32'd2);
    check_val("head_still_00", 32'(read_data), 32'h00);

    // Full with simultaneous push and pop; drain to see 0x55 last
    step(1, 8'h55, 1, 0);
    check_val("full_pushpop_head", 32'(read_data), 32'h01);
    for (int i = 0; i < 15; i++) step(0, 8'h00, 1, 0);
    check_val("last_is_55", 32'(read_data), 32'h55);
    step(0, 8'h00, 1, 0);

    // Empty with simultaneous push and pop
    step(1, 8'h7E, 1, 0);
    check_val("empty_pushpop", 32'(read_data), 32'h7E);
    step(0, 8'h00, 1, 0);

    // Saturation and clear priority
    for (int i = 0; i < 16; i++) step(1, 8'($urandom), 0, 0);
    for (int i = 0; i < 300; i++) step(1, 8'($urandom), 0, 0);
    check_val("drop_saturated", 32'(dropped_count), 32'd255);
    step(1, 8'hEE, 0, 1);
    check_val("clear_vs_drop", 32'(dropped_count), 32'd1);
    step(0, 8'h00, 0, 1);
    check_val("clear_alone", 32'(overflow), 32'd0);

    // Wrap at 1-deep occupancy
    do_reset();
    step(1, 8'h00, 0, 0);
    for (int i = 1; i <= 40; i++) step(1, 8'(i * 3), 1, 0);
    step(0, 8'h00, 1, 0);

    // Mid-stream reset
    for (int i = 0; i < 5; i++) step(1, 8'(8'h90 + i), 0, 0);
    do_reset();
    step(1, 8'h33, 0, 0);
    check_val("after_reset_33", 32'(read_data), 32'h33);

    // Randomized traffic in phases of varying fill pressure
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 150; i++) begin
        step(($urandom_range(99) < 30 + ph * 15), 8'($urandom),
             ($urandom_range(99) < 65 - ph * 15), ($urandom_range(99) < 4));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
